data_mem_bus_ctrl: RTL
======================

Name: data_mem_bus_ctrl

Overview:
- Sequential memory-bus stage directly downstream of the memory control unit. It consumes that unit's address-bus select, data-access address, read/write toggle and store data.
- It arbitrates between an instruction-fetch address and a data-access address, owns a word-addressed data RAM, and inserts a configurable number of wait states.
- It returns load data on data_bus_in and fetched instructions on instr_out, with busy/done handshake signals for the pipeline.

Parameters:
DATA_W, 32, data word width
ADDR_W, 16, bus address width in words
DEPTH_LOG2, 10, log2 of RAM depth in words (1024 words)
WAIT_STATES, 2, wait cycles inserted before each access (legal range 0..15)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  1  access request, sampled only in IDLE
add_bus_sel  input  1  1 = data access, 0 = instruction fetch
fetch_address  input  ADDR_W  instruction fetch word address
add_buss_data_access  input  ADDR_W  data access word address
read_write_toggle  input  1  1 = read, 0 = write (data access only)
data_bus_out  input  DATA_W  store data from memory control unit
data_bus_in  output  DATA_W  load data returned to memory control unit
instr_out  output  DATA_W  fetched instruction word
mem_busy  output  1  access in progress
mem_done  output  1  one-cycle access-complete pulse
addr_err  output  1  last completed access was out of range

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values:
  - data_bus_in = 0, instr_out = 0, mem_busy = 0, mem_done = 0, addr_err = 0, FSM = IDLE, wait counter = 0.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, ACCESS.
- IDLE:
  - On a rising edge with req = 1, latch add_bus_sel, the selected address (add_bus_sel ? add_buss_data_access : fetch_address), read_write_toggle and data_bus_out.
  - Load the wait counter with WAIT_STATES.
  - Go to WAIT if WAIT_STATES > 0, else go to ACCESS.
  - With req = 0, stay in IDLE.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to ACCESS. Total time in WAIT is exactly WAIT_STATES cycles.
- ACCESS (one cycle); on the exiting edge:
  - Perform the access using latched values only.
  - Set mem_done = 1 for exactly one cycle.
  - Update addr_err.
  - Return to IDLE.
- Latency:
  - mem_done is high in the cycle following edge E0+WAIT_STATES+1, where E0 is the edge that accepted req.
  - WAIT_STATES = 2: done is visible 3 edges after acceptance. WAIT_STATES = 0: done is visible 1 edge after acceptance.
- mem_busy = (state != IDLE), registered with the state.
  - mem_busy is high for WAIT_STATES+1 cycles.
  - mem_busy is low in the mem_done cycle.
- Access types:
  - Fetch (latched sel = 0): RAM read into instr_out. read_write_toggle is ignored. data_bus_in is held.
  - Data read (sel = 1, rw = 1): RAM read into data_bus_in. instr_out is held.
  - Data write (sel = 1, rw = 0): RAM[addr] <= latched store data. data_bus_in and instr_out are held.
- Range check:
  - An address is out of range if address bits [ADDR_W-1:DEPTH_LOG2] are not all zero.
  - Out-of-range write: no RAM update.
  - Out-of-range read: the destination output is loaded with 0.
  - addr_err = 1 with the corresponding mem_done. addr_err holds until the next completed access, which rewrites it.
- Input changes:
  - req high while busy is ignored; it neither queues nor aborts.
  - Changes on any input during WAIT/ACCESS have no effect, because all values are latched.
- Back-to-back access:
  - req high in the mem_done cycle starts a new access (FSM is IDLE).
  - The requester drops req in the done cycle unless it is issuing another access.
- Reset mid-operation:
  - Asserting rst_n low in WAIT or ACCESS before the ACCESS exit edge aborts the access.
  - No RAM write occurs, no mem_done pulse is produced, and outputs go to reset values immediately.
- Writes become visible to a subsequent read of the same address with no forwarding required, since accesses are serialized.

Test Plan:
- Write then read (WAIT_STATES = 2): write 0xDEADBEEF to address 0x0010, then read address 0x0010. Required: data_bus_in = 0xDEADBEEF, mem_done 3 edges after each accepting edge, mem_busy high for 3 cycles.
- Fetch path: preload RAM[0x0004] = 0x12345678; req with add_bus_sel = 0, fetch_address = 0x0004, read_write_toggle = 0. Required: instr_out = 0x12345678, data_bus_in unchanged, RAM unchanged.
- Out of range: write to 0x0400 with 0xAAAA5555, then read 0x0400. Required: addr_err = 1 on both done pulses, data_bus_in = 0, RAM[0x0000] unchanged. A following in-range read clears addr_err to 0.
- Request while busy: hold req high during WAIT and change the address to 0x0020. Required: exactly one access to the originally latched address. A second access is accepted only in the done cycle if req is still high.
- Zero wait states (WAIT_STATES = 0): back-to-back reads of 0x0001 and 0x0002. Required: mem_done on consecutive-access cadence of 2 edges each; mem_busy high for 1 cycle per access.
- Reset mid-write: issue a write of 0xCAFEF00D to 0x0030 and pull rst_n low during WAIT. Required: outputs immediately 0, no mem_done pulse, and a subsequent read of 0x0030 returns the prior contents.

Source files
------------

// File: rtl/data_mem_bus_ctrl.sv
// Memory-bus stage behind the memory control unit: arbitrates fetch vs data
// address, owns a word-addressed data RAM and inserts WAIT_STATES wait cycles.
module data_mem_bus_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              add_bus_sel,
  input  logic [ADDR_W-1:0] fetch_address,
  input  logic [ADDR_W-1:0] add_buss_data_access,
  input  logic              read_write_toggle,
  input  logic [DATA_W-1:0] data_bus_out,
  output logic [DATA_W-1:0] data_bus_in,
  output logic [DATA_W-1:0] instr_out,
  output logic              mem_busy,
  output logic              mem_done,
  output logic              addr_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Handshake: req is sampled only while idle; mem_busy is high from the
  // accepting edge until the access edge, and mem_done pulses for one cycle
  // after it. A req seen in the mem_done cycle starts the next access.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                sel_q, sel_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   dbi_q, dbi_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                in_range;
  logic [DATA_W-1:0]   rd_word;
  logic                ram_we;

  assign in_range = (addr_q[ADDR_W-1:DEPTH_LOG2] == '0);
  assign rd_word  = mem[addr_q[DEPTH_LOG2-1:0]];
  assign ram_we   = (state_q == S_ACCESS) && sel_q && !rw_q && in_range;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dbi_d   = dbi_q;
    instr_d = instr_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          sel_d   = add_bus_sel;
          addr_d  = add_bus_sel ? add_buss_data_access : fetch_address;
          rw_d    = read_write_toggle;
          wdata_d = data_bus_out;
          cnt_d   = 4'(WAIT_STATES);
          state_d = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = 4'(cnt_q - 4'd1);
        if (cnt_q == 4'd1) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        err_d   = !in_range;
        // Out-of-range reads return zero; writes are dropped via ram_we.
        if (!sel_q)   instr_d = in_range ? rd_word : '0;
        else if (rw_q) dbi_d  = in_range ? rd_word : '0;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dbi_q   <= '0;
      instr_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dbi_q   <= dbi_d;
      instr_q <= instr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // RAM is not reset; an async reset forces IDLE, so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (ram_we) mem[addr_q[DEPTH_LOG2-1:0]] <= wdata_q;
  end

  assign data_bus_in = dbi_q;
  assign instr_out   = instr_q;
  assign mem_busy    = busy_q;
  assign mem_done    = done_q;
  assign addr_err    = err_q;

endmodule
